// File: rtl/mux3_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mux3_rr_arbiter_if
// Brief     : Requester/sink handshake bundle for the 3-way round-robin arbiter
// Revision  : 1.0
// ============================================================================
interface mux3_rr_arbiter_if #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
);
  logic [2:0]       req;
  logic [2:0]       src_valid;
  logic [2:0]       src_last;
  logic [2:0]       src_ready;
  logic             sink_valid;
  logic             sink_ready;
  logic [1:0]       sel;
  logic [2:0]       grant;
  logic             busy;
  logic [CNT_W-1:0] beat_count;

  // master: requesters + sink side; slave: the arbiter
  modport master (
    output req, src_valid, src_last, sink_ready,
    input  src_ready, sink_valid, sel, grant, busy, beat_count
  );

  modport slave (
    input  req, src_valid, src_last, sink_ready,
    output src_ready, sink_valid, sel, grant, busy, beat_count
  );
endinterface
`default_nettype wire

// File: rtl/mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : mux3_rr_arbiter
// Brief     : Burst round-robin arbiter for three word streams onto one sink
// Revision  : 1.0
// ============================================================================
module mux3_rr_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mux3_rr_arbiter_if.slave bus
);

  localparam logic [0:0]       S_IDLE      = 1'b0;
  localparam logic [0:0]       S_BURST     = 1'b1;
  localparam logic [1:0]       C_SEL_NONE  = 2'b11;
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST - 1);

  logic [0:0]       r_state;
  logic [1:0]       r_sel;
  logic [2:0]       r_grant;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [1:0]       r_last_grant;

  logic             w_sink_valid;
  logic [2:0]       w_src_ready;
  logic             w_cur_last;
  logic             w_cur_req;
  logic             w_beat;
  logic             w_burst_end;
  logic [1:0]       w_pick;

  // Priority order starts just after the last granted index; scanning from
  // lowest priority upward lets the highest-priority requester win.
  function automatic logic [1:0] f_next(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] idx;
    f_next = C_SEL_NONE;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % 3);
      if (req[idx]) f_next = idx;
    end
  endfunction

  // Handshake routing is combinational from registered sel, so an async
  // reset drops sink_valid/src_ready in the same cycle.
  always_comb begin
    w_sink_valid = 1'b0;
    w_src_ready  = 3'b000;
    w_cur_last   = 1'b0;
    w_cur_req    = 1'b0;
    case (r_sel)
      2'd0: begin
        w_sink_valid = bus.src_valid[0];
        w_src_ready  = {2'b00, bus.sink_ready};
        w_cur_last   = bus.src_last[0];
        w_cur_req    = bus.req[0];
      end
      2'd1: begin
        w_sink_valid = bus.src_valid[1];
        w_src_ready  = {1'b0, bus.sink_ready, 1'b0};
        w_cur_last   = bus.src_last[1];
        w_cur_req    = bus.req[1];
      end
      2'd2: begin
        w_sink_valid = bus.src_valid[2];
        w_src_ready  = {bus.sink_ready, 2'b00};
        w_cur_last   = bus.src_last[2];
        w_cur_req    = bus.req[2];
      end
      default: begin
        w_sink_valid = 1'b0;
        w_src_ready  = 3'b000;
        w_cur_last   = 1'b0;
        w_cur_req    = 1'b0;
      end
    endcase
  end

  assign w_beat      = w_sink_valid & bus.sink_ready;
  assign w_burst_end = w_beat & (w_cur_last | (r_beat_cnt == C_LAST_BEAT));
  assign w_pick      = f_next(r_last_grant, bus.req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sel        <= C_SEL_NONE;
      r_grant      <= 3'b000;
      r_beat_cnt   <= '0;
      r_last_grant <= 2'd2;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_state    <= S_BURST;
            r_sel      <= w_pick;
            r_grant    <= 3'(3'b001 << w_pick);
            r_beat_cnt <= '0;
          end
        end
        S_BURST: begin
          // A beat always completes; an abort (req dropped) only wins on an idle cycle.
          if (w_burst_end || (!w_beat && !w_cur_req)) begin
            r_state      <= S_IDLE;
            r_sel        <= C_SEL_NONE;
            r_grant      <= 3'b000;
            r_beat_cnt   <= '0;
            r_last_grant <= r_sel;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= C_SEL_NONE;
          r_grant <= 3'b000;
        end
      endcase
    end
  end

  assign bus.sink_valid = w_sink_valid;
  assign bus.src_ready  = w_src_ready;
  assign bus.sel        = r_sel;
  assign bus.grant      = r_grant;
  assign bus.busy       = (r_state == S_BURST);
  assign bus.beat_count = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_mux3_rr_arbiter
// Brief     : Directed + reference-model checks for mux3_rr_arbiter
// Revision  : 1.0
// ============================================================================
module tb_mux3_rr_arbiter;

  localparam int MAX_BURST = 16;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  logic clk = 1'b0;
  logic r_reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux3_rr_arbiter_if #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) bus ();

  mux3_rr_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (r_reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] req, input logic [2:0] vld,
                        input logic [2:0] lst, input logic rdy);
    bus.req        = req;
    bus.src_valid  = vld;
    bus.src_last   = lst;
    bus.sink_ready = rdy;
  endtask

  task automatic do_reset();
    r_reset = 1'b1;
    set_in(3'b000, 3'b000, 3'b000, 1'b0);
    tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_sel",   32'(bus.sel),   32'h3);
    chk("rst_cnt",   32'(bus.beat_count), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_sv",    32'(bus.sink_valid), 32'h0);
    chk("rst_sr",    32'(bus.src_ready),  32'h0);
    r_reset = 1'b0;
  endtask

  // Reference model state
  int m_state, m_sel, m_cnt, m_lg, idx;
  int wait_cnt [3];
  int max_wait;
  logic m_beat, m_sv;
  logic [2:0] m_sr;

  initial begin
    logic [2:0] exp_g [7];
    exp_g = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

    // 1: rotation with single-beat bursts
    do_reset();
    set_in(3'b111, 3'b111, 3'b111, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), 32'(bus.grant), 32'(exp_g[i]));
    end
    chk("rr_sel", 32'(bus.sel), 32'h0);

    // 2: beat cap at MAX_BURST
    do_reset();
    set_in(3'b010, 3'b111, 3'b000, 1'b1);
    tick();
    chk("cap_grant", 32'(bus.grant), 32'h2);
    chk("cap_cnt0",  32'(bus.beat_count), 32'h0);
    for (int i = 0; i < MAX_BURST - 1; i++) tick();
    chk("cap_cnt15", 32'(bus.beat_count), 32'(MAX_BURST - 1));
    chk("cap_busy",  32'(bus.busy), 32'h1);
    tick();
    chk("cap_idle",  32'(bus.grant), 32'h0);
    chk("cap_sel3",  32'(bus.sel), 32'h3);
    tick();
    chk("cap_regrant", 32'(bus.grant), 32'h2);

    // 3: sink_ready toggling
    do_reset();
    set_in(3'b001, 3'b111, 3'b000, 1'b0);
    tick();
    chk("tog_grant", 32'(bus.grant), 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus.sink_ready = (i % 2 == 0);
      #1;
      chk($sformatf("tog_sr%0d", i), 32'(bus.src_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("tog_sv%0d", i), 32'(bus.sink_valid), 32'h1);
      tick();
      chk($sformatf("tog_cnt%0d", i), 32'(bus.beat_count), 32'(i / 2 + 1));
    end

    // 4: abort on dropped req without a beat, then rotate to 1
    set_in(3'b010, 3'b111, 3'b000, 1'b0);
    bus.req = 3'b011;
    bus.req[0] = 1'b0;
    tick();
    chk("abort_grant", 32'(bus.grant), 32'h0);
    chk("abort_sel",   32'(bus.sel),   32'h3);
    bus.req = 3'b011;
    tick();
    chk("abort_next",  32'(bus.grant), 32'h2);
    chk("abort_nsel",  32'(bus.sel),   32'h1);

    // 5: async reset mid-burst
    do_reset();
    set_in(3'b001, 3'b111, 3'b000, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("mid_cnt5", 32'(bus.beat_count), 32'h5);
    #2 r_reset = 1'b1;
    #1;
    chk("mid_grant", 32'(bus.grant), 32'h0);
    chk("mid_sel",   32'(bus.sel),   32'h3);
    chk("mid_sv",    32'(bus.sink_valid), 32'h0);
    chk("mid_cnt",   32'(bus.beat_count), 32'h0);
    set_in(3'b100, 3'b111, 3'b000, 1'b1);
    #1 r_reset = 1'b0;
    tick();
    chk("mid_regrant", 32'(bus.grant), 32'h4);

    // 6: random traffic against a reference model
    do_reset();
    m_state = 0; m_sel = 3; m_cnt = 0; m_lg = 2; max_wait = 0;
    for (int j = 0; j < 3; j++) wait_cnt[j] = 0;
    for (int c = 0; c < 2000; c++) begin
      bus.req        = 3'($urandom_range(0, 7));
      bus.src_valid  = 3'($urandom_range(0, 7));
      for (int j = 0; j < 3; j++) bus.src_last[j] = ($urandom_range(0, 7) == 0);
      bus.sink_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_sv   = (m_state == 1) ? bus.src_valid[m_sel] : 1'b0;
      m_sr   = (m_state == 1 && bus.sink_ready) ? 3'(3'b001 << m_sel) : 3'b000;
      m_beat = m_sv & bus.sink_ready;
      chk("rnd_sv",    32'(bus.sink_valid), 32'(m_sv));
      chk("rnd_sr",    32'(bus.src_ready),  32'(m_sr));
      chk("rnd_grant", 32'(bus.grant), (m_state == 1) ? (32'h1 << m_sel) : 32'h0);
      chk("rnd_sel",   32'(bus.sel),   (m_state == 1) ? 32'(m_sel) : 32'h3);
      chk("rnd_cnt",   32'(bus.beat_count), 32'(m_cnt));
      chk("rnd_onehot0", 32'($onehot0(bus.grant)), 32'h1);
      chk("rnd_sel_busy", 32'(bus.sel == 2'b11), 32'(!bus.busy));
      if (m_state == 0) begin
        if (bus.req != 3'b000) begin
          idx = 3;
          for (int k = 3; k >= 1; k--) if (bus.req[(m_lg + k) % 3]) idx = (m_lg + k) % 3;
          for (int j = 0; j < 3; j++) begin
            if (j == idx || !bus.req[j]) wait_cnt[j] = 0;
            else wait_cnt[j]++;
            if (wait_cnt[j] > max_wait) max_wait = wait_cnt[j];
          end
          m_state = 1; m_sel = idx; m_cnt = 0;
        end
      end else begin
        if (m_beat && (bus.src_last[m_sel] || m_cnt == MAX_BURST - 1)) begin
          m_lg = m_sel; m_state = 0; m_sel = 3; m_cnt = 0;
        end else if (m_beat) begin
          m_cnt++;
        end else if (!bus.req[m_sel]) begin
          m_lg = m_sel; m_state = 0; m_sel = 3; m_cnt = 0;
        end
      end
      tick();
    end
    chk("rnd_starve", 32'(max_wait <= 2), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
